// File: rtl/if_pkg.sv
// Shared fetch-side types and constants for the IF -> ID instruction queue.
package if_pkg;
    localparam int          INSTR_W   = 32;
    localparam int          PC_W      = 32;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
    localparam logic [31:0] PC_RESET  = 32'h0000_3000;

    typedef struct packed {
        logic [PC_W-1:0]    pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;
endpackage

// File: rtl/if_queue_ptr.sv
// Wrap-around queue pointer: load wins over increment, wraps naturally at 2**AW.
module if_queue_ptr #(
    parameter int AW = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          inc,
    input  logic          load,
    input  logic [AW-1:0] load_val,
    output logic [AW-1:0] ptr
);
    logic [AW-1:0] ptr_reg;
    logic [AW-1:0] ptr_next;

    always_comb begin
        ptr_next = ptr_reg;
        if (load) begin
            ptr_next = load_val;
        end else if (inc) begin
            ptr_next = ptr_reg + AW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr_reg <= '0;
        end else begin
            ptr_reg <= ptr_next;
        end
    end

    assign ptr = ptr_reg;
endmodule

// File: rtl/if_id_queue.sv
// Fetch-side instruction queue between PC/IM and decode, with valid/ready
// handshakes on both sides and a flush that discards wrong-path entries.
module if_id_queue
    import if_pkg::*;
#(
    parameter int          DEPTH     = 4,
    parameter int          AW        = $clog2(DEPTH),
    parameter logic [31:0] NOP_INSTR = if_pkg::NOP_INSTR
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    input  logic [PC_W-1:0]    in_pc,
    input  logic [INSTR_W-1:0] in_instr,
    output logic               in_ready,
    input  logic               flush,
    output logic               out_valid,
    output logic [PC_W-1:0]    out_pc,
    output logic [INSTR_W-1:0] out_instr,
    input  logic               out_ready,
    output logic [AW:0]        count
);
    localparam logic [AW:0] COUNT_FULL = (AW+1)'(DEPTH);

    fetch_entry_t mem_reg [DEPTH];
    fetch_entry_t head;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count_reg;
    logic [AW:0]   count_next;
    logic          push;
    logic          pop;
    logic          push_ok;
    logic          pop_ok;

    // Handshake state comes only from registered occupancy, so in_ready never
    // depends on out_ready and there is no full-queue pass-through.
    assign in_ready  = (count_reg != COUNT_FULL);
    assign out_valid = (count_reg != '0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;
    assign push_ok   = push & ~flush;
    assign pop_ok    = pop & ~flush;

    always_comb begin
        count_next = count_reg;
        if (flush) begin
            count_next = '0;
        end else if (push_ok && !pop_ok) begin
            count_next = count_reg + (AW+1)'(1);
        end else if (pop_ok && !push_ok) begin
            count_next = count_reg - (AW+1)'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

    if_queue_ptr #(.AW(AW)) u_wr_ptr (
        .clk      (clk),
        .reset    (reset),
        .inc      (push_ok),
        .load     (1'b0),
        .load_val ('0),
        .ptr      (wr_ptr)
    );

    // Flush empties the queue by snapping the read side onto the write side.
    if_queue_ptr #(.AW(AW)) u_rd_ptr (
        .clk      (clk),
        .reset    (reset),
        .inc      (pop_ok),
        .load     (flush),
        .load_val (wr_ptr),
        .ptr      (rd_ptr)
    );

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
        always_ff @(posedge clk) begin
            if (push_ok && (wr_ptr == AW'(gi))) begin
                mem_reg[gi] <= '{pc: in_pc, instr: in_instr};
            end
        end
    end

    assign head      = mem_reg[rd_ptr];
    assign out_pc    = out_valid ? head.pc    : '0;
    assign out_instr = out_valid ? head.instr : NOP_INSTR;
    assign count     = count_reg;
endmodule

// File: tb/tb_if_id_queue.sv
// Directed bench for if_id_queue: vector table plus streaming and async-reset sequences.
module tb_if_id_queue;
    import if_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [31:0] in_pc;
    logic [31:0] in_instr;
    logic        in_ready;
    logic        flush;
    logic        out_valid;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
    logic        out_ready;
    logic [2:0]  count;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic        iv;
        logic [31:0] pc;
        logic [31:0] ins;
        logic        fl;
        logic        ordy;
        logic        e_ov;
        logic [31:0] e_pc;
        logic [31:0] e_ins;
        logic [2:0]  e_cnt;
        logic        e_ir;
    } vec_t;

    vec_t vecs[$];

    if_id_queue dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_pc     (in_pc),
        .in_instr  (in_instr),
        .in_ready  (in_ready),
        .flush     (flush),
        .out_valid (out_valid),
        .out_pc    (out_pc),
        .out_instr (out_instr),
        .out_ready (out_ready),
        .count     (count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk_state(input string tag, input logic ov, input logic [31:0] pc,
                             input logic [31:0] ins, input logic [2:0] cnt, input logic ir);
        chk({tag, ".out_valid"}, 32'(out_valid), 32'(ov));
        chk({tag, ".out_pc"},    out_pc,         pc);
        chk({tag, ".out_instr"}, out_instr,      ins);
        chk({tag, ".count"},     32'(count),     32'(cnt));
        chk({tag, ".in_ready"},  32'(in_ready),  32'(ir));
    endtask

    function automatic vec_t v(input logic iv, input logic [31:0] pc, input logic [31:0] ins,
                               input logic fl, input logic ordy, input logic e_ov,
                               input logic [31:0] e_pc, input logic [31:0] e_ins,
                               input logic [2:0] e_cnt, input logic e_ir);
        vec_t r;
        r.iv = iv; r.pc = pc; r.ins = ins; r.fl = fl; r.ordy = ordy;
        r.e_ov = e_ov; r.e_pc = e_pc; r.e_ins = e_ins; r.e_cnt = e_cnt; r.e_ir = e_ir;
        return r;
    endfunction

    task automatic drive_step(input logic iv, input logic [31:0] pc, input logic [31:0] ins,
                              input logic fl, input logic ordy);
        in_valid  = iv;
        in_pc     = pc;
        in_instr  = ins;
        flush     = fl;
        out_ready = ordy;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b0;
        in_valid = 1'b0; in_pc = '0; in_instr = '0; flush = 1'b0; out_ready = 1'b0;

        // single push, then drain
        vecs.push_back(v(1, 32'h3000, 32'h3C01_1234, 0, 0, 1, 32'h3000, 32'h3C01_1234, 1, 1));
        vecs.push_back(v(0, 32'h0,    32'h0,         0, 1, 0, 32'h0,    32'h0,         0, 1));
        // fill to full, blocked fifth push, drain in order
        vecs.push_back(v(1, 32'h3000, 32'h1111_0000, 0, 0, 1, 32'h3000, 32'h1111_0000, 1, 1));
        vecs.push_back(v(1, 32'h3004, 32'h2222_0000, 0, 0, 1, 32'h3000, 32'h1111_0000, 2, 1));
        vecs.push_back(v(1, 32'h3008, 32'h3333_0000, 0, 0, 1, 32'h3000, 32'h1111_0000, 3, 1));
        vecs.push_back(v(1, 32'h300C, 32'h4444_0000, 0, 0, 1, 32'h3000, 32'h1111_0000, 4, 0));
        vecs.push_back(v(1, 32'h3010, 32'h5555_0000, 0, 0, 1, 32'h3000, 32'h1111_0000, 4, 0));
        vecs.push_back(v(0, 32'h0,    32'h0,         0, 1, 1, 32'h3004, 32'h2222_0000, 3, 1));
        vecs.push_back(v(0, 32'h0,    32'h0,         0, 1, 1, 32'h3008, 32'h3333_0000, 2, 1));
        vecs.push_back(v(0, 32'h0,    32'h0,         0, 1, 1, 32'h300C, 32'h4444_0000, 1, 1));
        vecs.push_back(v(0, 32'h0,    32'h0,         0, 1, 0, 32'h0,    32'h0,         0, 1));
        // count=3, then flush with simultaneous push and pop
        vecs.push_back(v(1, 32'h3020, 32'hAAAA_0001, 0, 0, 1, 32'h3020, 32'hAAAA_0001, 1, 1));
        vecs.push_back(v(1, 32'h3024, 32'hAAAA_0002, 0, 0, 1, 32'h3020, 32'hAAAA_0001, 2, 1));
        vecs.push_back(v(1, 32'h3028, 32'hAAAA_0003, 0, 0, 1, 32'h3020, 32'hAAAA_0001, 3, 1));
        vecs.push_back(v(1, 32'h3040, 32'hAAAA_0040, 1, 1, 0, 32'h0,    32'h0,         0, 1));
        vecs.push_back(v(1, 32'h4000, 32'hBBBB_0000, 0, 0, 1, 32'h4000, 32'hBBBB_0000, 1, 1));
        // push+pop with one entry: head replaced, count unchanged
        vecs.push_back(v(1, 32'h4004, 32'hCCCC_0000, 0, 1, 1, 32'h4004, 32'hCCCC_0000, 1, 1));
        vecs.push_back(v(0, 32'h0,    32'h0,         1, 0, 0, 32'h0,    32'h0,         0, 1));
        // flush while empty
        vecs.push_back(v(0, 32'h0,    32'h0,         1, 0, 0, 32'h0,    32'h0,         0, 1));
        // flush while full, then reuse
        vecs.push_back(v(1, 32'h5000, 32'hDDDD_0000, 0, 0, 1, 32'h5000, 32'hDDDD_0000, 1, 1));
        vecs.push_back(v(1, 32'h5004, 32'hDDDD_0001, 0, 0, 1, 32'h5000, 32'hDDDD_0000, 2, 1));
        vecs.push_back(v(1, 32'h5008, 32'hDDDD_0002, 0, 0, 1, 32'h5000, 32'hDDDD_0000, 3, 1));
        vecs.push_back(v(1, 32'h500C, 32'hDDDD_0003, 0, 0, 1, 32'h5000, 32'hDDDD_0000, 4, 0));
        vecs.push_back(v(0, 32'h0,    32'h0,         1, 0, 0, 32'h0,    32'h0,         0, 1));
        vecs.push_back(v(1, 32'h6000, 32'hEEEE_0000, 0, 0, 1, 32'h6000, 32'hEEEE_0000, 1, 1));
        vecs.push_back(v(0, 32'h0,    32'h0,         0, 1, 0, 32'h0,    32'h0,         0, 1));

        // reset held for 3 clocks
        repeat (3) @(posedge clk);
        #1;
        chk("reset.out_valid", 32'(out_valid), 32'd0);
        chk("reset.out_instr", out_instr, NOP_INSTR);
        chk("reset.out_pc",    out_pc,    32'd0);
        chk("reset.count",     32'(count), 32'd0);
        reset = 1'b1;
        #1;
        chk("release.in_ready", 32'(in_ready), 32'd1);
        $display("reset released: in_ready=%0d count=%0d", in_ready, count);

        foreach (vecs[i]) begin
            drive_step(vecs[i].iv, vecs[i].pc, vecs[i].ins, vecs[i].fl, vecs[i].ordy);
            $display("vec %0d: iv=%0d pc=%h fl=%0d ordy=%0d -> ov=%0d out_pc=%h cnt=%0d ir=%0d",
                     i, vecs[i].iv, vecs[i].pc, vecs[i].fl, vecs[i].ordy,
                     out_valid, out_pc, count, in_ready);
            chk_state($sformatf("vec%0d", i), vecs[i].e_ov, vecs[i].e_pc, vecs[i].e_ins,
                      vecs[i].e_cnt, vecs[i].e_ir);
        end

        // streaming: 20 cycles of push+pop, head advances by 4 each cycle
        for (int k = 0; k < 20; k++) begin
            logic [31:0] pc_k;
            pc_k = PC_RESET + 32'(4 * k);
            drive_step(1'b1, pc_k, 32'h9000_0000 + 32'(k), 1'b0, 1'b1);
            $display("stream %0d: push pc=%h -> out_pc=%h cnt=%0d", k, pc_k, out_pc, count);
            chk($sformatf("stream%0d.out_pc", k), out_pc, pc_k);
            chk($sformatf("stream%0d.out_instr", k), out_instr, 32'h9000_0000 + 32'(k));
            chk($sformatf("stream%0d.count", k), 32'(count), 32'd1);
        end
        drive_step(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
        chk_state("stream_drain", 1'b0, 32'h0, 32'h0, 3'd0, 1'b1);

        // async reset between edges with count=2
        drive_step(1'b1, 32'h7000, 32'hF000_0000, 1'b0, 1'b0);
        drive_step(1'b1, 32'h7004, 32'hF000_0001, 1'b0, 1'b0);
        chk("pre_async.count", 32'(count), 32'd2);
        in_valid = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        $display("async reset: out_valid=%0d count=%0d", out_valid, count);
        chk("async.out_valid", 32'(out_valid), 32'd0);
        chk("async.count",     32'(count),     32'd0);
        chk("async.out_instr", out_instr,      NOP_INSTR);
        @(negedge clk);
        reset = 1'b1;
        drive_step(1'b1, 32'h8000, 32'h1234_5678, 1'b0, 1'b0);
        chk_state("post_async", 1'b1, 32'h8000, 32'h1234_5678, 3'd1, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
